// File: rtl/wgt_stream_loader_if.sv
// Signal bundle between the weight-stream loader, the layer controller, the weight SRAM
// and the PE-row shift buffers. WGT_LOADER_CHKSUM_EN adds the chksum output.
interface wgt_stream_loader_if #(
    parameter int DW  = 8,
    parameter int AW  = 10,
    parameter int NKW = 8
);
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [NKW-1:0] num_kern;
    logic           hold;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_rdata;
    logic [DW-1:0]  wgt_data;
    logic           wgt_read;
    logic           busy;
    logic           done;
`ifdef WGT_LOADER_CHKSUM_EN
    logic [15:0]    chksum;

    modport master (
        input  start, base_addr, num_kern, hold, mem_rdata,
        output mem_rd_en, mem_addr, wgt_data, wgt_read, busy, done, chksum
    );

    modport slave (
        output start, base_addr, num_kern, hold, mem_rdata,
        input  mem_rd_en, mem_addr, wgt_data, wgt_read, busy, done, chksum
    );
`else
    modport master (
        input  start, base_addr, num_kern, hold, mem_rdata,
        output mem_rd_en, mem_addr, wgt_data, wgt_read, busy, done
    );

    modport slave (
        output start, base_addr, num_kern, hold, mem_rdata,
        input  mem_rd_en, mem_addr, wgt_data, wgt_read, busy, done
    );
`endif
endinterface

// File: rtl/wgt_stream_loader.sv
// Streams num_kern kernels of KSIZE weights from the weight SRAM into the PE-row shift
// buffers, one word per cycle. WGT_LOADER_CHKSUM_EN adds a running 16-bit weight checksum.
//
//   state   | meaning
//   S_IDLE  | waiting for start; parameters latched on start
//   S_RUN   | issuing KSIZE consecutive SRAM reads for one kernel
//   S_DRAIN | 2 read-free cycles while the kernel's last words are delivered
//   S_PAUSE | consumer requested hold at a kernel boundary; no strobes
//   S_DONE  | one-cycle done pulse, then back to idle
module wgt_stream_loader #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int KSIZE = 9,
    parameter int NKW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    wgt_stream_loader_if.master bus
);
    localparam int WCW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(KSIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [NKW-1:0] nk_q, nk_d;
    logic [NKW-1:0] kcnt_q, kcnt_d;
    logic [NKW-1:0] kcnt_inc;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           dcnt_q, dcnt_d;
    logic           rd_en;

    logic           rd_pend_q;
    logic           wgt_read_q;
    logic [DW-1:0]  wgt_data_q;

    assign kcnt_inc = kcnt_q + NKW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            nk_q    <= '0;
            kcnt_q  <= '0;
            wcnt_q  <= '0;
            dcnt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nk_q    <= nk_d;
            kcnt_q  <= kcnt_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nk_d    = nk_q;
        kcnt_d  = kcnt_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
        rd_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    nk_d    = bus.num_kern;
                    kcnt_d  = '0;
                    wcnt_d  = '0;
                    dcnt_d  = 1'b0;
                    state_d = (bus.num_kern == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Address runs straight through all kernels; wraps modulo 2^AW.
                rd_en  = 1'b1;
                addr_d = addr_q + AW'(1);
                if (wcnt_q == WCNT_LAST) begin
                    wcnt_d  = '0;
                    dcnt_d  = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_DRAIN: begin
                if (!dcnt_q) begin
                    dcnt_d = 1'b1;
                end else begin
                    dcnt_d = 1'b0;
                    kcnt_d = kcnt_inc;
                    if (kcnt_inc == nk_q) begin
                        state_d = S_DONE;
                    end else if (bus.hold) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_PAUSE: begin
                if (!bus.hold) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-stage delivery: SRAM returns data one cycle after the strobe, then it is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            wgt_read_q <= 1'b0;
            wgt_data_q <= '0;
        end else begin
            rd_pend_q  <= rd_en;
            wgt_read_q <= rd_pend_q;
            if (rd_pend_q) begin
                wgt_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = addr_q;
    assign bus.wgt_data  = wgt_data_q;
    assign bus.wgt_read  = wgt_read_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);

`ifdef WGT_LOADER_CHKSUM_EN
    logic        start_acc;
    logic [15:0] chksum_q;

    assign start_acc = (state_q == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum_q <= '0;
        end else if (start_acc) begin
            chksum_q <= '0;
        end else if (wgt_read_q) begin
            chksum_q <= chksum_q + 16'($signed(wgt_data_q));
        end
    end

    assign bus.chksum = chksum_q;
`endif

endmodule

// File: tb/tb_wgt_stream_loader.sv
// Directed bench for wgt_stream_loader: SRAM model plus address/data/latency scoreboard.
// Build with WGT_LOADER_CHKSUM_EN defined to also exercise the checksum output.
module tb_wgt_stream_loader;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int KSIZE = 9;
    localparam int NKW   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wgt_stream_loader_if #(.DW(DW), .AW(AW), .NKW(NKW)) bus ();

    wgt_stream_loader #(.DW(DW), .AW(AW), .KSIZE(KSIZE), .NKW(NKW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rd, n_wr, n_bursts, min_gap, last_wr_cyc, done_cyc;
    logic [AW-1:0] last_rd_addr;
    logic [15:0]   done_chk;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            rd_cyc_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe the loader produces is matched against what the bench queued at start.
    always @(negedge clk) begin
        if (bus.mem_rd_en) begin
            n_rd++;
            last_rd_addr = bus.mem_addr;
            rd_cyc_q.push_back(cyc);
            if (exp_addr_q.size() == 0) chk("rd_unexpected", exp_addr_q.size(), 1);
            else chk("rd_addr", bus.mem_addr, exp_addr_q.pop_front());
        end
        if (bus.wgt_read) begin
            n_wr++;
            if (last_wr_cyc != cyc - 1) begin
                n_bursts++;
                if (last_wr_cyc >= 0 && (cyc - last_wr_cyc - 1) < min_gap)
                    min_gap = cyc - last_wr_cyc - 1;
            end
            last_wr_cyc = cyc;
            if (exp_data_q.size() == 0 || rd_cyc_q.size() == 0) begin
                chk("wr_unexpected", exp_data_q.size(), 1);
            end else begin
                chk("wgt_data", bus.wgt_data, exp_data_q.pop_front());
                chk("wgt_latency", cyc, rd_cyc_q.pop_front() + 2);
            end
        end
    end

    task automatic clr_stats();
        n_rd = 0; n_wr = 0; n_bursts = 0; min_gap = 1000; last_wr_cyc = -100;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [NKW-1:0] nk);
        logic [AW-1:0] a;
        clr_stats();
        for (int kn = 0; kn < int'(nk); kn++) begin
            for (int k = 0; k < KSIZE; k++) begin
                a = base + AW'(kn * KSIZE + k);
                exp_addr_q.push_back(a);
                exp_data_q.push_back(mem[a]);
            end
        end
        bus.base_addr = base;
        bus.num_kern  = nk;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!bus.done && i < budget) begin
            @(negedge clk);
            i++;
        end
        done_cyc = cyc;
`ifdef WGT_LOADER_CHKSUM_EN
        done_chk = bus.chksum;
`endif
        chk("done_seen", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("busy_after_done", bus.busy, 0);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int i;
        i = 0;
        while (n_wr < target && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("wr_reached", n_wr >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        bus.start = 1'b0; bus.hold = 1'b0; bus.base_addr = '0; bus.num_kern = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        clr_stats();
        repeat (3) @(negedge clk);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_wgt_read", bus.wgt_read, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wgt_data", bus.wgt_data, 0);
`ifdef WGT_LOADER_CHKSUM_EN
        chk("rst_chksum", bus.chksum, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // single kernel, data 1..9
        for (int k = 0; k < KSIZE; k++) mem[10'h010 + k] = DW'(k + 1);
        start_job(10'h010, 1);
        chk("t1_busy_rise", bus.busy, 1);
        wait_done(100);
        chk("t1_rd_count", n_rd, 9);
        chk("t1_wr_count", n_wr, 9);
        chk("t1_bursts", n_bursts, 1);
        chk("t1_last_addr", last_rd_addr, 10'h018);
        chk("t1_done_after_last", done_cyc, last_wr_cyc + 1);
        chk("t1_sb_empty", exp_data_q.size(), 0);

        // three kernels back to back
        start_job(10'h100, 3);
        wait_done(300);
        chk("t2_rd_count", n_rd, 27);
        chk("t2_wr_count", n_wr, 27);
        chk("t2_bursts", n_bursts, 3);
        chk("t2_gap_ge2", min_gap >= 2, 1);
        chk("t2_last_addr", last_rd_addr, 10'h11A);
        chk("t2_done_after_last", done_cyc, last_wr_cyc + 1);
        chk("t2_sb_empty", exp_addr_q.size(), 0);

        // hold raised during kernel 0
        start_job(10'h180, 2);
        bus.hold = 1'b1;
        wait_wr(9, 50);
        repeat (2) @(negedge clk);
        #1;
        chk("t3_k0_words", n_wr, 9);
        chk("t3_k0_reads", n_rd, 9);
        r0 = n_rd; w0 = n_wr;
        repeat (10) @(negedge clk);
        #1;
        chk("t3_pause_rd", n_rd, r0);
        chk("t3_pause_wr", n_wr, w0);
        chk("t3_pause_busy", bus.busy, 1);
        chk("t3_pause_done", bus.done, 0);
        bus.hold = 1'b0;
        wait_done(100);
        chk("t3_wr_count", n_wr, 18);
        chk("t3_rd_count", n_rd, 18);
        chk("t3_sb_empty", exp_data_q.size(), 0);

        // zero kernels, then start coinciding with done
        start_job(10'h050, 0);
        chk("t4_done_next", bus.done, 1);
        chk("t4_busy_at_done", bus.busy, 0);
        bus.base_addr = 10'h300; bus.num_kern = 8'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_reads", n_rd, 0);
        chk("t4_no_writes", n_wr, 0);
        chk("t4_start_at_done_ignored", bus.busy, 0);

        // start mid-stream is ignored
        @(negedge clk);
        start_job(10'h200, 1);
        repeat (3) @(negedge clk);
        bus.base_addr = 10'h000; bus.num_kern = 8'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(100);
        chk("t4_mid_rd_count", n_rd, 9);
        chk("t4_mid_last_addr", last_rd_addr, 10'h208);

        // address wrap
        start_job(10'h3FC, 1);
        wait_done(100);
        chk("t5_rd_count", n_rd, 9);
        chk("t5_last_addr", last_rd_addr, 10'h004);
        chk("t5_sb_empty", exp_addr_q.size(), 0);

        // reset mid-stream
        start_job(10'h050, 4);
        wait_wr(3, 50);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5r_rd_en", bus.mem_rd_en, 0);
        chk("t5r_wgt_read", bus.wgt_read, 0);
        chk("t5r_busy", bus.busy, 0);
        chk("t5r_mem_addr", bus.mem_addr, 0);
        chk("t5r_wgt_data", bus.wgt_data, 0);
        exp_addr_q.delete(); exp_data_q.delete(); rd_cyc_q.delete();
        clr_stats();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("t5r_no_reads", n_rd, 0);
        chk("t5r_no_writes", n_wr, 0);
        chk("t5r_idle", bus.busy, 0);

`ifdef WGT_LOADER_CHKSUM_EN
        @(negedge clk);
        for (int k = 0; k < KSIZE; k++) mem[10'h020 + k] = 8'h80;
        start_job(10'h020, 1);
        chk("t6_chksum_cleared", bus.chksum, 0);
        wait_done(100);
        chk("t6_chksum_neg", done_chk, 16'hFB80);
        chk("t6_chksum_stable", bus.chksum, 16'hFB80);
        start_job(10'h010, 1);
        wait_done(100);
        chk("t6_chksum_pos", done_chk, 16'd45);
        chk("t6_chksum_stable2", bus.chksum, 16'd45);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
